// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: commits only complete, error-free frames from the MAC
// and replays them to the DMA; errored or overflowing frames are rolled back whole.
module eth_rx_frame_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [63:0]           s_axis_tdata,
  input  logic [7:0]            s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_W-1:0]      stat_frames_ok,
  output logic [CNT_W-1:0]      stat_frames_err,
  output logic [CNT_W-1:0]      stat_frames_ovf,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned EW    = 73;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     commit_q, commit_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     raddr_q, raddr_d;
  logic [PW-1:0]     level_q, level_d;
  logic              tready_q;
  logic              rvld_q, rvld_d;
  logic              mvld_q, mvld_d;
  logic [EW-1:0]     mdata_q, mdata_d;
  logic [CNT_W-1:0]  ok_q, ok_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic [EW-1:0]     ram_dout_q;
  logic [EW-1:0]     mem [DEPTH];

  logic beat, full, wr_en;
  logic avail, out_fire, move, rd_issue;

  // Write side: accept beats, commit on good tlast, roll back on error or overflow.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    commit_d = commit_q;
    ok_d     = ok_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    beat     = s_axis_tvalid && tready_q;
    full     = (wr_q - rd_q) == PW'(DEPTH);
    case (state_q)
      ST_IDLE, ST_RECV: begin
        if (beat) begin
          if (!full) begin
            wr_en   = 1'b1;
            wr_d    = wr_q + PW'(1);
            state_d = ST_RECV;
            if (s_axis_tlast) begin
              state_d = ST_IDLE;
              if (s_axis_tuser) begin
                wr_d  = commit_q;
                err_d = err_q + CNT_W'(1);
              end else begin
                commit_d = wr_q + PW'(1);
                ok_d     = ok_q + CNT_W'(1);
              end
            end
          end else begin
            wr_d    = commit_q;
            ovf_d   = ovf_q + CNT_W'(1);
            state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (beat && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read side: RAM read stage feeding a one-entry output register; raddr runs ahead of rd,
  // which only moves once a beat is handed to the DMA, so prefetched slots stay reserved.
  always_comb begin
    avail    = raddr_q != commit_q;
    out_fire = mvld_q && m_axis_tready;
    move     = rvld_q && (!mvld_q || m_axis_tready);
    rd_issue = avail && (!rvld_q || move);
    raddr_d  = rd_issue ? raddr_q + PW'(1) : raddr_q;
    rd_d     = out_fire ? rd_q + PW'(1) : rd_q;
    rvld_d   = rd_issue ? 1'b1 : (move ? 1'b0 : rvld_q);
    mvld_d   = move ? 1'b1 : (out_fire ? 1'b0 : mvld_q);
    mdata_d  = move ? ram_dout_q : mdata_q;
    level_d  = wr_d - rd_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      raddr_q  <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
      rvld_q   <= 1'b0;
      mvld_q   <= 1'b0;
      mdata_q  <= '0;
      ok_q     <= '0;
      err_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
      raddr_q  <= raddr_d;
      level_q  <= level_d;
      tready_q <= 1'b1;
      rvld_q   <= rvld_d;
      mvld_q   <= mvld_d;
      mdata_q  <= mdata_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // Frame storage; read port registered (latency 1).
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_q[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_issue) ram_dout_q <= mem[raddr_q[DEPTH_LOG2-1:0]];
  end

  assign s_axis_tready   = tready_q;
  assign m_axis_tvalid   = mvld_q;
  assign m_axis_tlast    = mdata_q[72];
  assign m_axis_tkeep    = mdata_q[71:64];
  assign m_axis_tdata    = mdata_q[63:0];
  assign stat_frames_ok  = ok_q;
  assign stat_frames_err = err_q;
  assign stat_frames_ovf = ovf_q;
  assign fifo_level      = level_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo: a 512-beat and a 16-beat instance, driven by frame-level
// stimulus and checked against an expected-beat queue built from the frame rules.
module tb_eth_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_user = 1'b0;
  logic        s_valid_b = 1'b0, s_valid_s = 1'b0;
  logic        rdy_b = 1'b1, rdy_s = 1'b1;

  logic        tready_b, tready_s;
  logic [63:0] m_data_b, m_data_s;
  logic [7:0]  m_keep_b, m_keep_s;
  logic        m_last_b, m_last_s, m_vld_b, m_vld_s;
  logic [31:0] ok_b, err_b, ovf_b, ok_s, err_s, ovf_s;
  logic [9:0]  level_b;
  logic [4:0]  level_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [72:0] exp_b[$], got_b[$], exp_s[$], got_s[$];
  int          cyc_b[$];

  eth_rx_frame_fifo #(.DEPTH_LOG2(9), .CNT_W(32)) dut_big (
    .clock(clk), .reset(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user), .s_axis_tvalid(s_valid_b), .s_axis_tready(tready_b),
    .m_axis_tdata(m_data_b), .m_axis_tkeep(m_keep_b), .m_axis_tlast(m_last_b),
    .m_axis_tvalid(m_vld_b), .m_axis_tready(rdy_b),
    .stat_frames_ok(ok_b), .stat_frames_err(err_b), .stat_frames_ovf(ovf_b),
    .fifo_level(level_b)
  );

  eth_rx_frame_fifo #(.DEPTH_LOG2(4), .CNT_W(32)) dut_small (
    .clock(clk), .reset(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user), .s_axis_tvalid(s_valid_s), .s_axis_tready(tready_s),
    .m_axis_tdata(m_data_s), .m_axis_tkeep(m_keep_s), .m_axis_tlast(m_last_s),
    .m_axis_tvalid(m_vld_s), .m_axis_tready(rdy_s),
    .stat_frames_ok(ok_s), .stat_frames_err(err_s), .stat_frames_ovf(ovf_s),
    .fifo_level(level_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitors: collect transfers and check beats stay put while stalled.
  logic        pv_b = 1'b0, pr_b = 1'b0, pv_s = 1'b0, pr_s = 1'b0;
  logic [72:0] pbeat_b, pbeat_s;
  always @(negedge clk) begin
    if (rst) begin
      pv_b = 1'b0;
      pv_s = 1'b0;
    end else begin
      if (pv_b && !pr_b) begin
        total++;
        if ({m_vld_b, m_last_b, m_keep_b, m_data_b} !== {1'b1, pbeat_b}) begin
          bad++;
          $display("FAIL hold_big: got vld=%b beat=%h, need vld=1 beat=%h", m_vld_b,
                   {m_last_b, m_keep_b, m_data_b}, pbeat_b);
        end
      end
      if (pv_s && !pr_s) begin
        total++;
        if ({m_vld_s, m_last_s, m_keep_s, m_data_s} !== {1'b1, pbeat_s}) begin
          bad++;
          $display("FAIL hold_small: got vld=%b beat=%h, need vld=1 beat=%h", m_vld_s,
                   {m_last_s, m_keep_s, m_data_s}, pbeat_s);
        end
      end
      if (m_vld_b && rdy_b) begin
        got_b.push_back({m_last_b, m_keep_b, m_data_b});
        cyc_b.push_back(cyc);
      end
      if (m_vld_s && rdy_s) got_s.push_back({m_last_s, m_keep_s, m_data_s});
      pv_b = m_vld_b; pr_b = rdy_b; pbeat_b = {m_last_b, m_keep_b, m_data_b};
      pv_s = m_vld_s; pr_s = rdy_s; pbeat_s = {m_last_s, m_keep_s, m_data_s};
    end
  end

  task automatic clear_q();
    exp_b.delete(); got_b.delete(); cyc_b.delete();
    exp_s.delete(); got_s.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid_b = 1'b0; s_valid_s = 1'b0; s_last = 1'b0; s_user = 1'b0;
    rdy_b = 1'b1; rdy_s = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One frame of n beats into the selected instance (0 = big, 1 = small); expected beats
  // are queued only if the frame should come out.
  task automatic send_frame(input bit sel, input int n, input bit uerr, input bit expect_out,
                            input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid_b = 1'b0; s_valid_s = 1'b0;
        @(posedge clk); #1;
      end
      s_data = {$urandom, $urandom};
      s_last = (i == n - 1);
      s_keep = s_last ? 8'h0F : 8'hFF;
      s_user = uerr && s_last;
      if (sel) s_valid_s = 1'b1; else s_valid_b = 1'b1;
      if (expect_out) begin
        if (sel) exp_s.push_back({s_last, s_keep, s_data});
        else     exp_b.push_back({s_last, s_keep, s_data});
      end
      @(posedge clk); #1;
    end
    s_valid_b = 1'b0; s_valid_s = 1'b0; s_last = 1'b0; s_user = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int t = 0;
    while ((sel ? got_s.size() < exp_s.size() : got_b.size() < exp_b.size()) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic int first_diff(input bit sel);
    int n = sel ? exp_s.size() : exp_b.size();
    int g = sel ? got_s.size() : got_b.size();
    for (int i = 0; i < n && i < g; i++) begin
      if (sel ? (got_s[i] !== exp_s[i]) : (got_b[i] !== exp_b[i])) return i;
    end
    return (n == g) ? -1 : ((n < g) ? n : g);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({tready_b, m_vld_b, m_data_b, m_keep_b, m_last_b} !== 75'd0) begin
      bad++;
      $display("FAIL reset_out: got rdy=%b vld=%b data=%h keep=%h last=%b, need all 0",
               tready_b, m_vld_b, m_data_b, m_keep_b, m_last_b);
    end
    total++;
    if ({ok_b, err_b, ovf_b, level_b} !== 106'd0) begin
      bad++;
      $display("FAIL reset_stats: got ok=%0d err=%0d ovf=%0d level=%0d, need 0", ok_b, err_b,
               ovf_b, level_b);
    end
    total++;
    if ({tready_s, m_vld_s, level_s} !== 7'd0) begin
      bad++;
      $display("FAIL reset_small: got rdy=%b vld=%b level=%0d, need 0", tready_s, m_vld_s, level_s);
    end
    do_reset();
    total++;
    if (tready_b !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b need 1", tready_b);
    end
  endtask

  task automatic test_good_frames();
    int d, gaps, adj;
    do_reset();
    send_frame(0, 8, 0, 1, 0);
    send_frame(0, 1, 0, 1, 0);
    send_frame(0, 64, 0, 1, 0);
    drain(0);
    d = first_diff(0);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL good_data: first diff at beat %0d, got %0d beats need %0d", d, got_b.size(),
               exp_b.size());
    end
    total++;
    if (ok_b !== 32'd3) begin
      bad++;
      $display("FAIL good_ok: got %0d need 3", ok_b);
    end
    gaps = 0;
    for (int k = 1; k < got_b.size(); k++)
      if (!got_b[k-1][72] && cyc_b[k] != cyc_b[k-1] + 1) gaps++;
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL good_no_gap: got %0d in-frame bubbles need 0", gaps);
    end
    adj = (got_b.size() >= 9) ? cyc_b[8] - cyc_b[7] : -1;
    total++;
    if (adj != 1) begin
      bad++;
      $display("FAIL good_b2b: got spacing %0d between frame 1 and 2, need 1", adj);
    end
  endtask

  task automatic test_err_frame();
    int d;
    do_reset();
    send_frame(0, 10, 1, 0, 0);
    send_frame(0, 4, 0, 1, 0);
    drain(0);
    d = first_diff(0);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL err_data: first diff at beat %0d, got %0d beats need %0d", d, got_b.size(),
               exp_b.size());
    end
    total++;
    if ({err_b, ok_b} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL err_stats: got err=%0d ok=%0d need err=1 ok=1", err_b, ok_b);
    end
  endtask

  task automatic test_overflow_stalled();
    int d;
    do_reset();
    rdy_s = 1'b0;
    send_frame(1, 12, 0, 1, 0);
    send_frame(1, 8, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({level_s, ovf_s, ok_s} !== {5'd12, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL ovf_stalled: got level=%0d ovf=%0d ok=%0d need level=12 ovf=1 ok=1", level_s,
               ovf_s, ok_s);
    end
    rdy_s = 1'b1;
    drain(1);
    d = first_diff(1);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL ovf_drain_data: first diff at beat %0d, got %0d beats need %0d", d,
               got_s.size(), exp_s.size());
    end
    total++;
    if (level_s !== 5'd0) begin
      bad++;
      $display("FAIL ovf_drain_level: got %0d need 0", level_s);
    end
  endtask

  task automatic test_long_frame();
    int d;
    do_reset();
    send_frame(1, 20, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({ovf_s, ok_s, level_s} !== {32'd1, 32'd0, 5'd0} || got_s.size() != 0) begin
      bad++;
      $display("FAIL long_drop: got ovf=%0d ok=%0d level=%0d out=%0d need ovf=1 ok=0 level=0 out=0",
               ovf_s, ok_s, level_s, got_s.size());
    end
    send_frame(1, 3, 0, 1, 30);
    drain(1);
    d = first_diff(1);
    total++;
    if (d != -1 || ok_s !== 32'd1) begin
      bad++;
      $display("FAIL long_next: diff at %0d ok=%0d, need no diff ok=1", d, ok_s);
    end
  endtask

  task automatic test_back_to_back();
    int  d, n_ok, n_err;
    bit  done;
    do_reset();
    n_ok = 0; n_err = 0; done = 1'b0;
    fork
      begin
        for (int f = 0; f < 25; f++) begin
          int  len = int'($urandom_range(16, 1));
          bit  e = ($urandom_range(3) == 0);
          if (e) n_err++; else n_ok++;
          send_frame(0, len, e, !e, 30);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rdy_b = $urandom_range(1);
        end
      end
    join
    rdy_b = 1'b1;
    drain(0);
    d = first_diff(0);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL rand_data: first diff at beat %0d, got %0d beats need %0d", d, got_b.size(),
               exp_b.size());
    end
    total++;
    if (ok_b !== 32'(n_ok) || err_b !== 32'(n_err)) begin
      bad++;
      $display("FAIL rand_stats: got ok=%0d err=%0d need ok=%0d err=%0d", ok_b, err_b, n_ok, n_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    do_reset();
    rdy_b = 1'b0;
    send_frame(0, 3, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m_vld_b, ok_b} !== {1'b1, 32'd1}) begin
      bad++;
      $display("FAIL pre_abort: got vld=%b ok=%0d need vld=1 ok=1", m_vld_b, ok_b);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      s_data = {$urandom, $urandom}; s_keep = 8'hFF; s_last = 1'b0; s_valid_b = 1'b1;
      @(posedge clk); #1;
    end
    s_data = {$urandom, $urandom};
    rst = 1'b1;
    @(negedge clk);
    s_valid_b = 1'b0;
    total++;
    if ({m_vld_b, tready_b, ok_b, err_b, ovf_b, level_b} !== 108'd0) begin
      bad++;
      $display("FAIL abort_state: got vld=%b rdy=%b ok=%0d err=%0d ovf=%0d level=%0d need 0",
               m_vld_b, tready_b, ok_b, err_b, ovf_b, level_b);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(0, 2, 0, 1, 0);
    drain(0);
    d = first_diff(0);
    total++;
    if (d != -1 || ok_b !== 32'd1) begin
      bad++;
      $display("FAIL after_abort: diff at %0d ok=%0d, need no diff ok=1", d, ok_b);
    end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_err_frame();
    test_overflow_stalled();
    test_long_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
